// File: rtl/uart_tx_stream_if.sv
// Write-side bundle of the UART TX stream: byte push plus FIFO status.
interface uart_tx_stream_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [LW-1:0]        level;
  logic                 overflow;

  modport master (output wr_en, wr_data, input full, empty, level, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a byte FIFO; configurable width, parity, stop bits and inter-frame gap.
// state    | meaning
// S_IDLE   | line high, pop FIFO head when available
// S_START  | start bit (tx=0)
// S_DATA   | payload bits, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | STOP_BITS stop bits (tx=1)
// S_GAP    | forced idle of GAP_CYCLES (only when GAP_CYCLES != 0)
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 833,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CYCLES   = 44,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_stream_if.slave  wr_if,
  output logic             busy,
  output logic             tx
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int CMAX = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0]    DATA_TC = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_TC = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count, count_n;
  logic                 full_q, empty_q, overflow_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 tx_d;

  assign push = wr_if.wr_en && !full_q;
  assign head = mem[rd_ptr];

  assign wr_if.full     = full_q;
  assign wr_if.empty    = empty_q;
  assign wr_if.level    = count;
  assign wr_if.overflow = overflow_q;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_if.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_n;
      full_q     <= (count_n == LW'(FIFO_DEPTH));
      empty_q    <= (count_n == '0);
      overflow_q <= wr_if.wr_en && full_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (PARITY == 2) ? ~^head : ^head;
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == BIT_TC) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else cnt_n = cnt + 1'b1;
      end
      S_DATA: begin
        if (cnt == BIT_TC) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (bit_idx == DATA_TC) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else bit_n = bit_idx + 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      S_PARITY: begin
        if (cnt == BIT_TC) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end else cnt_n = cnt + 1'b1;
      end
      S_STOP: begin
        if (cnt == BIT_TC) begin
          cnt_n = '0;
          if (bit_idx == STOP_TC) begin
            bit_n   = '0;
            state_n = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else bit_n = bit_idx + 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      S_GAP: begin
        if (cnt == GAP_TC) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line level follows the next state so tx is a clean register aligned with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_n)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_n[0];
      S_PARITY: tx_d = par_n;
      default:  tx_d = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: three configurations, per-cycle frame monitors.
module tb_uart_tx_stream;
  localparam int CPB0 = 833, GAP0 = 44;
  localparam int CPB1 = 4, PAR1 = 1, STOP1 = 1, GAP1 = 3;
  localparam int CPB2 = 4, PAR2 = 2, STOP2 = 2, GAP2 = 0;
  localparam int PER1 = (1 + 8 + 1 + STOP1) * CPB1 + GAP1 + 1;
  localparam int PER2 = (1 + 8 + 1 + STOP2) * CPB2 + GAP2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n0, rst_n1, rst_n2;
  logic busy0, busy1, busy2, tx0, tx1, tx2;

  uart_tx_stream_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
  uart_tx_stream_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if1 ();
  uart_tx_stream_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if2 ();

  uart_tx_stream #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .GAP_CYCLES(GAP0), .FIFO_DEPTH(16))
    u0 (.clk(clk), .rst_n(rst_n0), .wr_if(if0), .busy(busy0), .tx(tx0));
  uart_tx_stream #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY(PAR1), .STOP_BITS(STOP1),
                   .GAP_CYCLES(GAP1), .FIFO_DEPTH(4))
    u1 (.clk(clk), .rst_n(rst_n1), .wr_if(if1), .busy(busy1), .tx(tx1));
  uart_tx_stream #(.CLKS_PER_BIT(CPB2), .DATA_BITS(8), .PARITY(PAR2), .STOP_BITS(STOP2),
                   .GAP_CYCLES(GAP2), .FIFO_DEPTH(4))
    u2 (.clk(clk), .rst_n(rst_n2), .wr_if(if2), .busy(busy2), .tx(tx2));

  int n_pass = 0, n_total = 0;
  logic [8:0] sb0[$], sb1[$], sb2[$];
  int starts[3][32];
  int nst[3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic get_tx(int s);
    case (s) 0: return tx0; 1: return tx1; default: return tx2; endcase
  endfunction
  function automatic logic get_busy(int s);
    case (s) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic get_rst(int s);
    case (s) 0: return rst_n0; 1: return rst_n1; default: return rst_n2; endcase
  endfunction
  function automatic int get_level(int s);
    case (s) 0: return int'(if0.level); 1: return int'(if1.level); default: return int'(if2.level); endcase
  endfunction
  function automatic logic get_full(int s);
    case (s) 0: return if0.full; 1: return if1.full; default: return if2.full; endcase
  endfunction
  function automatic logic get_empty(int s);
    case (s) 0: return if0.empty; 1: return if1.empty; default: return if2.empty; endcase
  endfunction
  function automatic logic get_ovf(int s);
    case (s) 0: return if0.overflow; 1: return if1.overflow; default: return if2.overflow; endcase
  endfunction

  function automatic void sb_push(int s, logic [8:0] v);
    case (s) 0: sb0.push_back(v); 1: sb1.push_back(v); default: sb2.push_back(v); endcase
  endfunction
  function automatic int sb_size(int s);
    case (s) 0: return sb0.size(); 1: return sb1.size(); default: return sb2.size(); endcase
  endfunction
  function automatic logic [8:0] sb_pop(int s);
    case (s) 0: return sb0.pop_front(); 1: return sb1.pop_front(); default: return sb2.pop_front(); endcase
  endfunction
  function automatic void sb_clear(int s);
    case (s) 0: sb0.delete(); 1: sb1.delete(); default: sb2.delete(); endcase
  endfunction

  task automatic drive(input int s, input logic en, input logic [7:0] d);
    case (s)
      0: begin if0.wr_en = en; if0.wr_data = d; end
      1: begin if1.wr_en = en; if1.wr_data = d; end
      default: begin if2.wr_en = en; if2.wr_data = d; end
    endcase
  endtask

  // Watches one line: every frame is compared cycle by cycle against the scoreboard head.
  task automatic monitor(input int sel, input int cpb, input int nb, input int par,
                         input int nstop, input int gap);
    int flen, errs, slot;
    logic [8:0] exp, dec;
    logic dpar, epar, etx;
    bit aborted;
    flen = (1 + nb + ((par != 0) ? 1 : 0) + nstop) * cpb;
    forever begin
      @(posedge clk); #1;
      if (get_rst(sel) && !get_tx(sel)) begin
        chk($sformatf("u%0d_frame_expected", sel), 32'(sb_size(sel) != 0), 1);
        exp = (sb_size(sel) != 0) ? sb_pop(sel) : 9'h0;
        exp = exp & (9'h1ff >> (9 - nb));
        epar = (par == 2) ? ~^exp : ^exp;
        if (nst[sel] < 32) begin
          starts[sel][nst[sel]] = cyc;
          nst[sel]++;
        end
        errs = 0; dec = '0; dpar = 1'b0; aborted = 1'b0;
        for (int c = 0; c <= flen + gap; c++) begin
          if (!get_rst(sel)) begin
            aborted = 1'b1;
            break;
          end
          slot = c / cpb;
          if (slot == 0)                       etx = 1'b0;
          else if (slot <= nb)                 etx = exp[slot-1];
          else if (par != 0 && slot == nb + 1) etx = epar;
          else                                 etx = 1'b1;
          if (get_tx(sel) !== etx) errs++;
          if (get_busy(sel) !== (c < flen + gap)) errs++;
          if (c % cpb == cpb / 2) begin
            if (slot >= 1 && slot <= nb) dec[slot-1] = get_tx(sel);
            else if (par != 0 && slot == nb + 1) dpar = get_tx(sel);
          end
          if (c < flen + gap) begin
            @(posedge clk); #1;
          end
        end
        if (!aborted) begin
          chk($sformatf("u%0d_wave_errs", sel), errs, 0);
          chk($sformatf("u%0d_data", sel), dec, exp);
          if (par != 0) chk($sformatf("u%0d_parity", sel), dpar, epar);
        end
      end
    end
  endtask

  initial monitor(0, CPB0, 8, 0, 1, GAP0);
  initial monitor(1, CPB1, 8, PAR1, STOP1, GAP1);
  initial monitor(2, CPB2, 8, PAR2, STOP2, GAP2);

  task automatic wait_idle(input int s, input int bound);
    int n;
    n = 0;
    while (!(sb_size(s) == 0 && !get_busy(s) && get_empty(s)) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d_drain_timeout", s), 32'(n >= bound), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, quiet, n0;
    int exp_lvl[6];
    logic [7:0] burst[6];
    exp_lvl = '{1, 1, 2, 3, 4, 4};
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++)
      chk($sformatf("u%0d_reset_state", s),
          {get_tx(s), get_busy(s), get_ovf(s), get_empty(s), get_full(s), 8'(get_level(s))},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    @(posedge clk); #1;

    // Default configuration: single 0x00 frame, latency and busy length.
    drive(0, 1'b1, 8'h00); sb_push(0, 9'h000);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00);
    chk("u0_level_after_write", get_level(0), 1);
    chk("u0_tx_before_pop", get_tx(0), 1);
    @(posedge clk); #1;
    chk("u0_tx_after_pop", get_tx(0), 0);
    chk("u0_empty_after_pop", get_empty(0), 1);
    n = 0;
    while (get_busy(0) && n < 20000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("u0_busy_len", n, 10 * CPB0 + GAP0);
    wait_idle(0, 100);

    // 0x07 with even and odd parity.
    drive(1, 1'b1, 8'h07); sb_push(1, 9'h007);
    drive(2, 1'b1, 8'h07); sb_push(2, 9'h007);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);
    wait_idle(1, 500);
    wait_idle(2, 500);

    // Six writes in six cycles into a depth-4 FIFO.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, burst[i]);
      if (i < 5) sb_push(1, {1'b0, burst[i]});
      @(posedge clk); #1;
      chk($sformatf("u1_burst_ovf_%0d", i), get_ovf(1), (i == 5));
      chk($sformatf("u1_burst_level_%0d", i), get_level(1), exp_lvl[i]);
    end
    drive(1, 1'b0, 8'h00);
    chk("u1_full_after_burst", get_full(1), 1);
    @(posedge clk); #1;
    chk("u1_ovf_single_pulse", get_ovf(1), 0);
    wait_idle(1, 2000);

    // Back-to-back frames: start spacing is frame + gap + pop cycle.
    n0 = nst[1];
    drive(1, 1'b1, 8'hA5); sb_push(1, 9'h0A5); @(posedge clk); #1;
    drive(1, 1'b1, 8'h3C); sb_push(1, 9'h03C); @(posedge clk); #1;
    drive(1, 1'b1, 8'hFF); sb_push(1, 9'h0FF); @(posedge clk); #1;
    drive(1, 1'b0, 8'h00);
    wait_idle(1, 1000);
    chk("u1_b2b_frames", nst[1] - n0, 3);
    chk("u1_b2b_period_a", starts[1][n0+1] - starts[1][n0], PER1);
    chk("u1_b2b_period_b", starts[1][n0+2] - starts[1][n0+1], PER1);

    // Two stop bits, no gap: next start one cycle after stop ends.
    n0 = nst[2];
    drive(2, 1'b1, 8'h55); sb_push(2, 9'h055); @(posedge clk); #1;
    drive(2, 1'b1, 8'h81); sb_push(2, 9'h081); @(posedge clk); #1;
    drive(2, 1'b0, 8'h00);
    wait_idle(2, 1000);
    chk("u2_frames", nst[2] - n0, 2);
    chk("u2_period", starts[2][n0+1] - starts[2][n0], PER2);

    // Reset in the middle of the data bits with three bytes still queued.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 8'(i * 17)); sb_push(1, 9'(i * 17));
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("u1_pre_reset_level", get_level(1), 3);
    chk("u1_pre_reset_tx_low", get_tx(1), 0);
    #3 rst_n1 = 1'b0;
    #1;
    chk("u1_reset_tx", get_tx(1), 1);
    chk("u1_reset_level", get_level(1), 0);
    chk("u1_reset_busy", get_busy(1), 0);
    chk("u1_reset_empty", get_empty(1), 1);
    sb_clear(1);
    repeat (3) @(posedge clk);
    #1 rst_n1 = 1'b1;
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!get_tx(1) || get_busy(1)) quiet++;
    end
    chk("u1_post_reset_quiet", quiet, 0);
    chk("u1_post_reset_level", get_level(1), 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
